// File: rtl/branch_resolve_unit.sv
// Branch resolution: compares two execute-lane outcomes with their fetch-time
// predictions, raises a one-cycle redirect, and queues predictor training updates.
module branch_resolve_unit #(
  parameter int QDEPTH = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             br_valid_0_i,
  input  logic             br_valid_1_i,
  input  logic             br_taken_0_i,
  input  logic             br_taken_1_i,
  input  logic [31:0]      br_pc_0_i,
  input  logic [31:0]      br_pc_1_i,
  input  logic [31:0]      br_tgt_0_i,
  input  logic [31:0]      br_tgt_1_i,
  input  logic             br_pred_0_i,
  input  logic             br_pred_1_i,
  input  logic [31:0]      br_pred_tgt_0_i,
  input  logic [31:0]      br_pred_tgt_1_i,
  output logic             wrong_pred_o,
  output logic [31:0]      fixed_pc_o,
  output logic [31:0]      update_pc_o,
  output logic [31:0]      update_tgt_o,
  output logic             last_br_o,
  output logic             update_pht_o,
  output logic             update_btb_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam logic [PTR_W:0] STALL_LVL = (PTR_W + 1)'(QDEPTH - 2);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
  } entry_t;

  // A taken branch that was predicted taken still mispredicts on a wrong target.
  function automatic logic lane_mis(input logic taken, input logic pred,
                                    input logic [31:0] tgt, input logic [31:0] pred_tgt);
    return (taken != pred) || (taken && pred && (tgt != pred_tgt));
  endfunction

  function automatic logic [31:0] lane_next_pc(input logic taken, input logic [31:0] pc,
                                               input logic [31:0] tgt);
    return taken ? tgt : pc + 32'd4;
  endfunction

  entry_t           mem [QDEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic             acc_0;
  logic             acc_1;
  logic             mis_0;
  logic             mis_1;
  logic             enq_0;
  logic             enq_1;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             deq;
  logic [1:0]       enq_num;
  logic [PTR_W:0]   count_next;
  logic [PTR_W-1:0] slot_1;
  entry_t           entry_0;
  entry_t           entry_1;
  entry_t           head;

  always_comb begin
    acc_0       = br_valid_0_i & ~stall_o & ~wrong_pred_o;
    acc_1       = br_valid_1_i & ~stall_o & ~wrong_pred_o;
    mis_0       = lane_mis(br_taken_0_i, br_pred_0_i, br_tgt_0_i, br_pred_tgt_0_i);
    mis_1       = lane_mis(br_taken_1_i, br_pred_1_i, br_tgt_1_i, br_pred_tgt_1_i);
    enq_0       = acc_0;
    // Everything younger than a mispredicting lane 0 is on the wrong path.
    enq_1       = acc_1 & ~(acc_0 & mis_0);
    redirect    = (acc_0 & mis_0) | (enq_1 & mis_1);
    redirect_pc = (acc_0 & mis_0) ? lane_next_pc(br_taken_0_i, br_pc_0_i, br_tgt_0_i)
                                  : lane_next_pc(br_taken_1_i, br_pc_1_i, br_tgt_1_i);
    deq         = (count != '0);
    enq_num     = {1'b0, enq_0} + {1'b0, enq_1};
    count_next  = count + (PTR_W + 1)'(enq_num) - (PTR_W + 1)'(deq);
    slot_1      = enq_0 ? wr_ptr + PTR_W'(1) : wr_ptr;
    entry_0     = '{pc: br_pc_0_i, tgt: br_tgt_0_i, taken: br_taken_0_i};
    entry_1     = '{pc: br_pc_1_i, tgt: br_tgt_1_i, taken: br_taken_1_i};
    head        = mem[rd_ptr];
  end

  // NOTE: queue storage has no reset; the count alone says which slots are live,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clock_i) begin
    if (enq_0) mem[wr_ptr] <= entry_0;
    if (enq_1) mem[slot_1] <= entry_1;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      stall_o <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + PTR_W'(enq_num);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_next;
      stall_o <= (count_next > STALL_LVL);
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wrong_pred_o  <= 1'b0;
      fixed_pc_o    <= '0;
      mispred_cnt_o <= '0;
    end else begin
      wrong_pred_o <= redirect;
      if (redirect) begin
        fixed_pc_o    <= redirect_pc;
        mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
      end
    end
  end

  // Training outputs hold their data while idle; only the strobes fall.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      update_pht_o <= 1'b0;
      update_btb_o <= 1'b0;
      last_br_o    <= 1'b0;
      update_pc_o  <= '0;
      update_tgt_o <= '0;
    end else if (deq) begin
      update_pht_o <= 1'b1;
      update_btb_o <= head.taken;
      last_br_o    <= head.taken;
      update_pc_o  <= head.pc;
      update_tgt_o <= head.tgt;
    end else begin
      update_pht_o <= 1'b0;
      update_btb_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a queue-based reference model checked
// every cycle, plus literal expectations for the headline scenarios.
module tb_branch_resolve_unit;

  localparam int QDEPTH = 4;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v0 = 0, v1 = 0, tk0 = 0, tk1 = 0, pr0 = 0, pr1 = 0;
  logic [31:0] pc0 = 0, pc1 = 0, tg0 = 0, tg1 = 0, pt0 = 0, pt1 = 0;

  logic             wrong_pred, last_br, update_pht, update_btb, stall;
  logic [31:0]      fixed_pc, update_pc, update_tgt;
  logic [CNT_W-1:0] mispred_cnt;

  int errors = 0;
  int checks = 0;

  branch_resolve_unit #(.QDEPTH(QDEPTH), .CNT_W(CNT_W)) dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .br_valid_0_i(v0), .br_valid_1_i(v1),
    .br_taken_0_i(tk0), .br_taken_1_i(tk1),
    .br_pc_0_i(pc0), .br_pc_1_i(pc1),
    .br_tgt_0_i(tg0), .br_tgt_1_i(tg1),
    .br_pred_0_i(pr0), .br_pred_1_i(pr1),
    .br_pred_tgt_0_i(pt0), .br_pred_tgt_1_i(pt1),
    .wrong_pred_o(wrong_pred), .fixed_pc_o(fixed_pc),
    .update_pc_o(update_pc), .update_tgt_o(update_tgt),
    .last_br_o(last_br), .update_pht_o(update_pht), .update_btb_o(update_btb),
    .stall_o(stall), .mispred_cnt_o(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
  } ent_t;

  ent_t        q[$];
  logic        m_wp, m_pht, m_btb, m_last, m_stall;
  logic [31:0] m_fixed, m_pc, m_tgt;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_wp = 0; m_pht = 0; m_btb = 0; m_last = 0; m_stall = 0;
      m_fixed = 0; m_pc = 0; m_tgt = 0; m_cnt = 0;
    end else begin
      logic a0, a1, bad0, bad1, new_wp;
      ent_t e;
      a0 = v0 && !m_stall && !m_wp;
      a1 = v1 && !m_stall && !m_wp;
      bad0 = (tk0 != pr0) || (tk0 && pr0 && tg0 != pt0);
      bad1 = (tk1 != pr1) || (tk1 && pr1 && tg1 != pt1);
      new_wp = 0;
      if (a0 && bad0) begin
        new_wp = 1; m_fixed = tk0 ? tg0 : pc0 + 4; a1 = 0;
      end else if (a1 && bad1) begin
        new_wp = 1; m_fixed = tk1 ? tg1 : pc1 + 4;
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        m_pht = 1; m_btb = e.taken; m_last = e.taken; m_pc = e.pc; m_tgt = e.tgt;
      end else begin
        m_pht = 0; m_btb = 0;
      end
      if (a0) q.push_back('{pc0, tg0, tk0});
      if (a1) q.push_back('{pc1, tg1, tk1});
      m_stall = q.size() > QDEPTH - 2;
      m_wp = new_wp;
      if (new_wp) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("wrong_pred", {31'b0, wrong_pred}, {31'b0, m_wp});
      check("fixed_pc", fixed_pc, m_fixed);
      check("update_pht", {31'b0, update_pht}, {31'b0, m_pht});
      check("update_btb", {31'b0, update_btb}, {31'b0, m_btb});
      check("last_br", {31'b0, last_br}, {31'b0, m_last});
      check("update_pc", update_pc, m_pc);
      check("update_tgt", update_tgt, m_tgt);
      check("stall", {31'b0, stall}, {31'b0, m_stall});
      check("mispred_cnt", {16'b0, mispred_cnt}, m_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_lane(input int l, input logic v, input logic tk, input logic [31:0] pc,
                          input logic [31:0] tg, input logic pr, input logic [31:0] pt);
    if (l == 0) begin v0 = v; tk0 = tk; pc0 = pc; tg0 = tg; pr0 = pr; pt0 = pt; end
    else        begin v1 = v; tk1 = tk; pc1 = pc; tg1 = tg; pr1 = pr; pt1 = pt; end
  endtask

  task automatic idle_lanes();
    v0 = 0; v1 = 0;
  endtask

  // Upstream behaviour: hold a correctly predicted not-taken pair until accepted.
  task automatic present_pair(input logic [31:0] a, input logic [31:0] b);
    bit done = 0;
    set_lane(0, 1, 0, a, 32'h0, 0, 32'h0);
    set_lane(1, 1, 0, b, 32'h0, 0, 32'h0);
    for (int i = 0; i < 20 && !done; i++) begin
      done = (stall == 0 && wrong_pred == 0);
      step();
    end
    check("pair_accept_timeout", {31'b0, done}, 32'd1);
  endtask

  initial begin
    #23 rst_n = 1;
    check("rst_pht", {31'b0, update_pht}, 32'd0);
    check("rst_cnt", {16'b0, mispred_cnt}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    @(negedge clk); step();

    // Correct taken branch: trained at N+2, no redirect.
    set_lane(0, 1, 1, 32'h100, 32'h200, 1, 32'h200);
    step(); idle_lanes();
    check("t2_no_redirect", {31'b0, wrong_pred}, 32'd0);
    step();
    check("t2_pht", {31'b0, update_pht}, 32'd1);
    check("t2_btb", {31'b0, update_btb}, 32'd1);
    check("t2_pc", update_pc, 32'h100);
    check("t2_tgt", update_tgt, 32'h200);
    step();

    // Lane 0 direction mispredict squashes lane 1.
    set_lane(0, 1, 0, 32'h40, 32'h0, 1, 32'h0);
    set_lane(1, 1, 1, 32'h44, 32'h60, 1, 32'h60);
    step(); idle_lanes();
    check("t3_wp", {31'b0, wrong_pred}, 32'd1);
    check("t3_fixed", fixed_pc, 32'h44);
    check("t3_cnt", {16'b0, mispred_cnt}, 32'd1);
    step();
    check("t3_pc", update_pc, 32'h40);
    check("t3_btb", {31'b0, update_btb}, 32'd0);
    check("t3_last", {31'b0, last_br}, 32'd0);
    check("t3_wp_drop", {31'b0, wrong_pred}, 32'd0);
    step();
    check("t3_no_lane1", {31'b0, update_pht}, 32'd0);

    // Lane 1 target mispredict behind a correct lane 0.
    set_lane(0, 1, 0, 32'h10, 32'h0, 0, 32'h0);
    set_lane(1, 1, 1, 32'h14, 32'h80, 1, 32'h90);
    step(); idle_lanes();
    check("t4_fixed", fixed_pc, 32'h80);
    check("t4_cnt", {16'b0, mispred_cnt}, 32'd2);
    step();
    check("t4_pc0", update_pc, 32'h10);
    step();
    check("t4_pc1", update_pc, 32'h14);
    check("t4_tgt1", update_tgt, 32'h80);
    check("t4_btb1", {31'b0, update_btb}, 32'd1);
    step();

    // Three back-to-back pairs: stall, hold, ordered drain across pointer wrap.
    present_pair(32'hA00, 32'hA04);
    present_pair(32'hB00, 32'hB04);
    check("t5_stall_rise", {31'b0, stall}, 32'd1);
    check("t5_pc_a0", update_pc, 32'hA00);
    present_pair(32'hC00, 32'hC04);
    idle_lanes();
    check("t5_pc_b0", update_pc, 32'hB00);
    step(); check("t5_pc_b1", update_pc, 32'hB04);
    step(); check("t5_pc_c0", update_pc, 32'hC00);
    step(); check("t5_pc_c1", update_pc, 32'hC04);
    step(); check("t5_drained", {31'b0, update_pht}, 32'd0);

    // Lanes presented while the redirect is high are wrong-path.
    set_lane(0, 1, 1, 32'h300, 32'h400, 0, 32'h0);
    step();
    set_lane(0, 1, 0, 32'h500, 32'h0, 0, 32'h0);
    set_lane(1, 1, 0, 32'h504, 32'h0, 0, 32'h0);
    check("t6_wp", {31'b0, wrong_pred}, 32'd1);
    check("t6_fixed", fixed_pc, 32'h400);
    step(); idle_lanes();
    check("t6_pc", update_pc, 32'h300);
    check("t6_cnt", {16'b0, mispred_cnt}, 32'd3);
    step();
    check("t6_dropped", {31'b0, update_pht}, 32'd0);
    check("t6_stall", {31'b0, stall}, 32'd0);

    // Mid-stream reset with three entries queued.
    present_pair(32'hD00, 32'hD04);
    present_pair(32'hE00, 32'hE04);
    idle_lanes();
    #2 rst_n = 0;
    #1;
    check("rst_mid_pht", {31'b0, update_pht}, 32'd0);
    check("rst_mid_pc", update_pc, 32'h0);
    check("rst_mid_stall", {31'b0, stall}, 32'd0);
    check("rst_mid_cnt", {16'b0, mispred_cnt}, 32'd0);
    check("rst_mid_fixed", fixed_pc, 32'h0);
    @(posedge clk); #3 rst_n = 1;
    step(); check("rst_post_pht0", {31'b0, update_pht}, 32'd0);
    step(); check("rst_post_pht1", {31'b0, update_pht}, 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Back-end counterpart of the fetch-stage predictor. Takes resolved branches from the two execute lanes and compares each outcome with the prediction carried down the pipe.
- Produces the single-port predictor update stream: update_pc, update_tgt, last_br, update_pht, update_btb.
- Produces the misprediction redirect: wrong_pred, fixed_pc.
- Buffers up to two resolutions per cycle in a small in-order queue, drained at one update per cycle.

Parameters:
- QDEPTH, 4, update-queue entries; power of two, at least 4.
- CNT_W, 16, width of the misprediction counter.

Ports:
- clock_i  in  1  system clock; all state changes on the rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- br_valid_0_i / br_valid_1_i  in  1  lane holds a resolved branch; lane 0 is older.
- br_taken_0_i / br_taken_1_i  in  1  actual branch direction.
- br_pc_0_i / br_pc_1_i  in  32  branch instruction address.
- br_tgt_0_i / br_tgt_1_i  in  32  actual target (meaningful when taken).
- br_pred_0_i / br_pred_1_i  in  1  predicted taken, carried from fetch.
- br_pred_tgt_0_i / br_pred_tgt_1_i  in  32  predicted target, carried from fetch.
- wrong_pred_o  out  1  one-cycle redirect pulse.
- fixed_pc_o  out  32  correct next PC; valid while wrong_pred_o is high.
- update_pc_o  out  32  address of the branch being trained.
- update_tgt_o  out  32  target to write into the BTB.
- last_br_o  out  1  actual direction for PHT training.
- update_pht_o  out  1  one-cycle PHT write strobe.
- update_btb_o  out  1  one-cycle BTB write strobe.
- stall_o  out  1  queue cannot accept two entries; upstream must hold the lanes.
- mispred_cnt_o  out  CNT_W  running count of mispredictions.

Behaviour:
- Reset (async, reset_n_i=0):
  - wrong_pred_o, update_pht_o, update_btb_o, last_br_o = 0.
  - fixed_pc_o, update_pc_o, update_tgt_o = 0.
  - Queue empty: count=0, read/write pointers=0, so stall_o=0.
  - mispred_cnt_o=0.
  - Reset mid-operation discards all queued entries and any pending redirect.
- Accept condition: a lane is accepted only if its valid is high, stall_o=0 and wrong_pred_o=0. Lanes presented while wrong_pred_o=1 are wrong-path and are dropped.
- Mispredict per lane, mis = (taken != pred) OR (taken AND pred AND tgt != pred_tgt).
- Correct PC per lane: taken ? tgt : pc+4, 32-bit wrapping add.
- Lane ordering:
  - If lane 0 is accepted and mispredicts, lane 1 is squashed: not enqueued, not counted.
  - Otherwise the first accepted mispredicting lane drives the redirect.
- Redirect: on the edge ending an accepting cycle with a mispredict, set wrong_pred_o=1 and load fixed_pc_o for exactly one cycle. fixed_pc_o then holds its value until the next redirect.
- mispred_cnt_o increments by 1 per redirect and wraps at 2^CNT_W.
- Enqueue: accepted, unsquashed lanes are written in order (lane 0 first) as {pc, tgt, taken}, 0, 1 or 2 entries per cycle. Write pointer wraps modulo QDEPTH.
- Dequeue:
  - Each edge, if count>0 before that edge, pop the head into the output registers.
  - update_pht_o=1 for one cycle; update_btb_o = head.taken; last_br_o = head.taken.
  - update_pc_o / update_tgt_o = head fields.
  - If the queue is empty, both strobes are 0 and the data outputs hold their last values.
- Latency: a branch resolved in cycle N appears on the update outputs in cycle N+2 when the queue was empty. The redirect appears in cycle N+1.
- Simultaneous enqueue and dequeue: count_next = count + enq − deq. No bypass from inputs to outputs.
- stall_o = (count > QDEPTH−2), registered from count_next. Never overflows; empty never underflows.

Test Plan:
- Reset mid-stream: queue holds 3 entries, pulse reset_n_i low -> all outputs 0 immediately, no strobes after release.
- Lane 0 {pc=0x100, taken=1, tgt=0x200, pred=1, pred_tgt=0x200}, lane 1 invalid -> no wrong_pred_o; at N+2: update_pht_o=1, update_btb_o=1, update_pc_o=0x100, update_tgt_o=0x200.
- Lane 0 {pc=0x40, taken=0, pred=1}, lane 1 valid -> at N+1: wrong_pred_o=1, fixed_pc_o=0x44, mispred_cnt_o=1; only 0x40 trained (update_btb_o=0, last_br_o=0); lane 1 never trained.
- Lane 0 correct at 0x10, lane 1 {pc=0x14, taken=1, tgt=0x80, pred=1, pred_tgt=0x90} -> fixed_pc_o=0x80 at N+1; updates 0x10 then 0x14 on consecutive cycles starting N+2.
- Both lanes valid and correct for 3 consecutive cycles -> stall_o rises once count>2; lanes held under stall are not enqueued; all 6 updates emerge in order, one per cycle, with pointer wrap.
- Valid lanes presented in the cycle wrong_pred_o=1 -> dropped: no enqueue, count unchanged.
